// File: rtl/proc_mmio_bus_pkg.sv
// Shared definitions for the MMIO unit: request types, default bases and address decode.
// Decode is purely combinational; the caller qualifies it with req_val.
package proc_mmio_bus_pkg;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

   localparam logic [31:0] OUT_BASE_DEFAULT = 32'h0000_0200;
   localparam logic [31:0] IN_BASE_DEFAULT  = 32'h0000_0280;

   typedef enum logic [1:0] {
      KIND_NONE,
      KIND_OUT,
      KIND_IN,
      KIND_STATUS
   } kind_e;

   typedef struct packed {
      kind_e      kind;
      logic [3:0] index;
   } decode_t;

   // Offsets are taken modulo 2^32, so an address below a base wraps high and fails the span test.
   function automatic decode_t addr_decode(input logic [31:0] addr,
                                           input logic [31:0] out_base,
                                           input logic [31:0] in_base,
                                           input logic [31:0] num_ch);
      decode_t     d;
      logic [31:0] span;
      logic [31:0] off_o;
      logic [31:0] off_i;
      span    = num_ch << 2;
      off_o   = addr - out_base;
      off_i   = addr - in_base;
      d.kind  = KIND_NONE;
      d.index = '0;
      if (addr[1:0] == 2'b00) begin
         if (off_o < span) begin
            d.kind  = KIND_OUT;
            d.index = 4'(off_o >> 2);
         end else if (off_i < span) begin
            d.kind  = KIND_IN;
            d.index = 4'(off_i >> 2);
         end else if (off_i == span) begin
            d.kind  = KIND_STATUS;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/proc_mmio_bus_if.sv
// Processor data-memory request/response bus as seen by the MMIO unit.
// hit is combinational from the request; the response follows one cycle later.
interface proc_mmio_bus_if;
   logic        req_val;
   logic        req_type;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        hit;
   logic        resp_val;
   logic [31:0] resp_rdata;

   modport master (
      output req_val, req_type, req_addr, req_wdata,
      input  hit, resp_val, resp_rdata
   );

   modport slave (
      input  req_val, req_type, req_addr, req_wdata,
      output hit, resp_val, resp_rdata
   );
endinterface

// File: rtl/proc_mmio_in_chan.sv
// Single-entry valid/ready input buffer popped by a processor read; capture takes 1 cycle.
// o_rdy = ~full, so a full buffer stalls the producer until the pop edge has passed.
module proc_mmio_in_chan (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_dat,
   input  logic        i_vld,
   output logic        o_rdy,
   input  logic        i_pop,
   output logic [31:0] o_dat,
   output logic        o_full
);

   logic        r_full;
   logic [31:0] r_dat;

   // Pop is checked first; when full, o_rdy is low so no capture could be due anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 1'b0;
         r_dat  <= '0;
      end else if (i_pop && r_full) begin
         r_full <= 1'b0;
      end else if (i_vld && !r_full) begin
         r_full <= 1'b1;
         r_dat  <= i_dat;
      end
   end

   assign o_rdy  = ~r_full;
   assign o_dat  = r_dat;
   assign o_full = r_full;

endmodule

// File: rtl/proc_mmio_bus.sv
// MMIO unit beside the processor data port: output registers, input buffers and status word.
// Response 1 cycle after a hit; never backpressures the processor.
module proc_mmio_bus
   import proc_mmio_bus_pkg::*;
#(
   parameter int unsigned  NUM_CHANNELS = 4,
   parameter logic [31:0] OUT_BASE     = OUT_BASE_DEFAULT,
   parameter logic [31:0] IN_BASE      = IN_BASE_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   proc_mmio_bus_if.slave               bus,
   output logic [NUM_CHANNELS-1:0][31:0] out,
   output logic [NUM_CHANNELS-1:0]       out_val,
   input  logic [NUM_CHANNELS-1:0][31:0] in,
   input  logic [NUM_CHANNELS-1:0]       in_val,
   output logic [NUM_CHANNELS-1:0]       in_rdy
);

   decode_t                        w_dec;
   logic                           w_hit;
   logic                           w_rd;
   logic [NUM_CHANNELS-1:0]        w_out_wr;
   logic [NUM_CHANNELS-1:0]        w_pop;
   logic [NUM_CHANNELS-1:0]        w_full;
   logic [NUM_CHANNELS-1:0][31:0]  w_in_dat;
   logic [31:0]                    w_rdata;

   logic [NUM_CHANNELS-1:0][31:0]  r_out;
   logic [NUM_CHANNELS-1:0]        r_out_val;
   logic                           r_resp_val;
   logic [31:0]                    r_resp_rdata;

   assign w_dec  = addr_decode(bus.req_addr, OUT_BASE, IN_BASE, 32'(NUM_CHANNELS));
   assign w_hit  = bus.req_val && (w_dec.kind != KIND_NONE);
   assign w_rd   = w_hit && (bus.req_type == REQ_READ);
   assign bus.hit = w_hit;

   always_comb begin
      w_out_wr = '0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
         w_out_wr[i] = w_hit && (bus.req_type == REQ_WRITE) &&
                       (w_dec.kind == KIND_OUT) && (w_dec.index == 4'(i));
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_in
      assign w_pop[g] = w_rd && (w_dec.kind == KIND_IN) && (w_dec.index == 4'(g));

      proc_mmio_in_chan u_chan (
         .clk    (clk),
         .rst    (rst),
         .i_dat  (in[g]),
         .i_vld  (in_val[g]),
         .o_rdy  (in_rdy[g]),
         .i_pop  (w_pop[g]),
         .o_dat  (w_in_dat[g]),
         .o_full (w_full[g])
      );
   end

   // Writes to input slots and the status word fall through with zero read data.
   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (w_dec.kind)
            KIND_OUT: begin
               for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                  if (w_dec.index == 4'(i)) w_rdata = r_out[i];
               end
            end
            KIND_IN: begin
               for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                  if ((w_dec.index == 4'(i)) && w_full[i]) w_rdata = w_in_dat[i];
               end
            end
            KIND_STATUS: w_rdata[NUM_CHANNELS-1:0] = w_full;
            default:     w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out        <= '0;
         r_out_val    <= '0;
         r_resp_val   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_out_val    <= w_out_wr;
         r_resp_val   <= w_hit;
         r_resp_rdata <= w_rdata;
         for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            if (w_out_wr[i]) r_out[i] <= bus.req_wdata;
         end
      end
   end

   assign out            = r_out;
   assign out_val        = r_out_val;
   assign bus.resp_val   = r_resp_val;
   assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_proc_mmio_bus.sv
// Directed self-checking bench for proc_mmio_bus with 4-channel and 8-channel instances.
module tb_proc_mmio_bus;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   proc_mmio_bus_if bus4 ();
   proc_mmio_bus_if bus8 ();

   logic [3:0][31:0] out4;
   logic [3:0]       out_val4;
   logic [3:0][31:0] in4;
   logic [3:0]       in_val4;
   logic [3:0]       in_rdy4;

   logic [7:0][31:0] out8;
   logic [7:0]       out_val8;
   logic [7:0][31:0] in8;
   logic [7:0]       in_val8;
   logic [7:0]       in_rdy8;

   proc_mmio_bus #(.NUM_CHANNELS(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4),
      .out(out4), .out_val(out_val4), .in(in4), .in_val(in_val4), .in_rdy(in_rdy4)
   );

   proc_mmio_bus #(.NUM_CHANNELS(8)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8),
      .out(out8), .out_val(out_val8), .in(in8), .in_val(in_val8), .in_rdy(in_rdy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request for one cycle; returns hit as seen before the accepting edge.
   task automatic req4(input logic typ, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic hit_seen);
      bus4.req_val   = 1'b1;
      bus4.req_type  = typ;
      bus4.req_addr  = addr;
      bus4.req_wdata = wdata;
      #1 hit_seen = bus4.hit;
      @(posedge clk); #1;
      bus4.req_val = 1'b0;
   endtask

   task automatic req8(input logic typ, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic hit_seen);
      bus8.req_val   = 1'b1;
      bus8.req_type  = typ;
      bus8.req_addr  = addr;
      bus8.req_wdata = wdata;
      #1 hit_seen = bus8.hit;
      @(posedge clk); #1;
      bus8.req_val = 1'b0;
   endtask

   task automatic test_reset();
      logic h;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (out4 !== '0) begin errors++; $display("FAIL reset_out got %h want 0", out4); end
      checks++; if (out_val4 !== 4'h0) begin errors++; $display("FAIL reset_out_val got %h want 0", out_val4); end
      checks++; if (in_rdy4 !== 4'hF) begin errors++; $display("FAIL reset_in_rdy got %h want f", in_rdy4); end
      checks++; if (bus4.resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val got %b want 0", bus4.resp_val); end
      req4(1'b0, 32'h200, 32'h0, h);
      checks++; if (h !== 1'b1) begin errors++; $display("FAIL reset_rd_hit got %b want 1", h); end
      checks++; if (bus4.resp_val !== 1'b1 || bus4.resp_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rd_resp got %b/%h want 1/0", bus4.resp_val, bus4.resp_rdata); end
   endtask

   task automatic test_out_write();
      logic h;
      req4(1'b1, 32'h200, 32'hDEADBEEF, h);
      checks++; if (out4[0] !== 32'hDEADBEEF || out_val4 !== 4'b0001) begin
         errors++; $display("FAIL wr0 got %h/%b want deadbeef/0001", out4[0], out_val4); end
      checks++; if (bus4.resp_val !== 1'b1 || bus4.resp_rdata !== 32'h0) begin
         errors++; $display("FAIL wr0_resp got %b/%h want 1/0", bus4.resp_val, bus4.resp_rdata); end
      req4(1'b1, 32'h20C, 32'h42, h);
      checks++; if (out4[3] !== 32'h42 || out_val4 !== 4'b1000) begin
         errors++; $display("FAIL wr3 got %h/%b want 42/1000", out4[3], out_val4); end
      req4(1'b0, 32'h200, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'hDEADBEEF || out_val4 !== 4'b0000) begin
         errors++; $display("FAIL rd0 got %h/%b want deadbeef/0000", bus4.resp_rdata, out_val4); end
      req4(1'b0, 32'h20C, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'h42) begin
         errors++; $display("FAIL rd3 got %h want 42", bus4.resp_rdata); end
   endtask

   task automatic test_back_to_back();
      logic h;
      req4(1'b1, 32'h204, 32'h1, h);
      checks++; if (out_val4 !== 4'b0010 || out4[1] !== 32'h1) begin
         errors++; $display("FAIL b2b_first got %b/%h want 0010/1", out_val4, out4[1]); end
      req4(1'b1, 32'h204, 32'h2, h);
      checks++; if (out_val4 !== 4'b0010 || out4[1] !== 32'h2) begin
         errors++; $display("FAIL b2b_second got %b/%h want 0010/2", out_val4, out4[1]); end
      req4(1'b0, 32'h204, 32'h0, h);
      checks++; if (out_val4 !== 4'b0000 || bus4.resp_rdata !== 32'h2) begin
         errors++; $display("FAIL b2b_readback got %b/%h want 0000/2", out_val4, bus4.resp_rdata); end
   endtask

   task automatic test_in_capture();
      logic h;
      in4[2] = 32'h1234; in_val4[2] = 1'b1;
      @(posedge clk); #1;
      in_val4[2] = 1'b0;
      checks++; if (in_rdy4 !== 4'b1011) begin errors++; $display("FAIL cap_rdy got %b want 1011", in_rdy4); end
      req4(1'b0, 32'h290, 32'h0, h);
      checks++; if (h !== 1'b1 || bus4.resp_rdata !== 32'h4) begin
         errors++; $display("FAIL cap_status got %b/%h want 1/4", h, bus4.resp_rdata); end
      req4(1'b0, 32'h288, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'h1234 || in_rdy4 !== 4'hF) begin
         errors++; $display("FAIL cap_pop got %h/%b want 1234/1111", bus4.resp_rdata, in_rdy4); end
      req4(1'b0, 32'h290, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'h0) begin
         errors++; $display("FAIL cap_status2 got %h want 0", bus4.resp_rdata); end
   endtask

   task automatic test_in_stall();
      logic h;
      in4[1] = 32'h7; in_val4[1] = 1'b1;
      @(posedge clk); #1;
      in4[1] = 32'h9;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_rdy4[1] !== 1'b0) begin errors++; $display("FAIL stall_rdy got %b want 0", in_rdy4[1]); end
      req4(1'b0, 32'h284, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'h7 || in_rdy4[1] !== 1'b1) begin
         errors++; $display("FAIL stall_pop got %h/%b want 7/1", bus4.resp_rdata, in_rdy4[1]); end
      @(posedge clk); #1;
      in_val4[1] = 1'b0;
      checks++; if (in_rdy4[1] !== 1'b0) begin errors++; $display("FAIL stall_recap got %b want 0", in_rdy4[1]); end
      req4(1'b0, 32'h284, 32'h0, h);
      checks++; if (bus4.resp_rdata !== 32'h9) begin
         errors++; $display("FAIL stall_pop2 got %h want 9", bus4.resp_rdata); end
   endtask

   task automatic test_empty_unmapped();
      logic h;
      req4(1'b0, 32'h284, 32'h0, h);
      checks++; if (bus4.resp_val !== 1'b1 || bus4.resp_rdata !== 32'h0) begin
         errors++; $display("FAIL empty_rd got %b/%h want 1/0", bus4.resp_val, bus4.resp_rdata); end
      req4(1'b0, 32'h202, 32'h0, h);
      checks++; if (h !== 1'b0 || bus4.resp_val !== 1'b0) begin
         errors++; $display("FAIL misaligned got hit=%b resp=%b want 0/0", h, bus4.resp_val); end
      req4(1'b0, 32'h300, 32'h0, h);
      checks++; if (h !== 1'b0 || bus4.resp_val !== 1'b0) begin
         errors++; $display("FAIL unmapped got hit=%b resp=%b want 0/0", h, bus4.resp_val); end
      req4(1'b1, 32'h202, 32'h55, h);
      checks++; if (h !== 1'b0 || out4[0] !== 32'hDEADBEEF || out_val4 !== 4'h0) begin
         errors++; $display("FAIL misaligned_wr got hit=%b out0=%h ov=%b want 0/deadbeef/0", h, out4[0], out_val4); end
      req4(1'b1, 32'h280, 32'h55, h);
      checks++; if (bus4.resp_val !== 1'b1 || bus4.resp_rdata !== 32'h0 || in_rdy4 !== 4'hF) begin
         errors++; $display("FAIL in_slot_wr got %b/%h/%b want 1/0/1111", bus4.resp_val, bus4.resp_rdata, in_rdy4); end
   endtask

   task automatic test_reset_inflight();
      in4[0] = 32'h55; in_val4[0] = 1'b1;
      @(posedge clk); #1;
      in_val4[0] = 1'b0;
      checks++; if (in_rdy4[0] !== 1'b0) begin errors++; $display("FAIL rstfl_fill got %b want 0", in_rdy4[0]); end
      bus4.req_val = 1'b1; bus4.req_type = 1'b1; bus4.req_addr = 32'h204; bus4.req_wdata = 32'hAA;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus4.req_val = 1'b0;
      checks++; if (bus4.resp_val !== 1'b0) begin errors++; $display("FAIL rstfl_resp got %b want 0", bus4.resp_val); end
      checks++; if (out4 !== '0 || out_val4 !== 4'h0) begin
         errors++; $display("FAIL rstfl_out got %h/%b want 0/0", out4, out_val4); end
      checks++; if (in_rdy4 !== 4'hF) begin errors++; $display("FAIL rstfl_full got %b want 1111", in_rdy4); end
      @(posedge clk); #1;
      checks++; if (out_val4 !== 4'h0 || out4[1] !== 32'h0) begin
         errors++; $display("FAIL rstfl_after got %b/%h want 0/0", out_val4, out4[1]); end
   endtask

   task automatic test_ch8();
      logic h;
      req8(1'b1, 32'h21C, 32'h77, h);
      checks++; if (h !== 1'b1 || out8[7] !== 32'h77 || out_val8 !== 8'h80) begin
         errors++; $display("FAIL ch8_wr7 got %b/%h/%h want 1/77/80", h, out8[7], out_val8); end
      in8[5] = 32'hABC; in_val8[5] = 1'b1;
      @(posedge clk); #1;
      in_val8[5] = 1'b0;
      req8(1'b0, 32'h2A0, 32'h0, h);
      checks++; if (h !== 1'b1 || bus8.resp_rdata !== 32'h20) begin
         errors++; $display("FAIL ch8_status got %b/%h want 1/20", h, bus8.resp_rdata); end
      req8(1'b0, 32'h294, 32'h0, h);
      checks++; if (bus8.resp_rdata !== 32'hABC || in_rdy8 !== 8'hFF) begin
         errors++; $display("FAIL ch8_pop5 got %h/%h want abc/ff", bus8.resp_rdata, in_rdy8); end
      req8(1'b0, 32'h2A4, 32'h0, h);
      checks++; if (h !== 1'b0 || bus8.resp_val !== 1'b0) begin
         errors++; $display("FAIL ch8_past_status got %b/%b want 0/0", h, bus8.resp_val); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus4.req_val = 1'b0; bus4.req_type = 1'b0; bus4.req_addr = '0; bus4.req_wdata = '0;
      bus8.req_val = 1'b0; bus8.req_type = 1'b0; bus8.req_addr = '0; bus8.req_wdata = '0;
      in4 = '0; in_val4 = '0;
      in8 = '0; in_val8 = '0;
      test_reset();
      test_out_write();
      test_back_to_back();
      test_in_capture();
      test_in_stall();
      test_empty_unmapped();
      test_reset_inflight();
      test_ch8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
